apb4_cmd_bridge: RTL and testbench
==================================

APB4_CMD_BRIDGE -- requirements
Module: apb4_cmd_bridge

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, bus data width (multiple of 8); ADDR_WIDTH, 32, address width; TIMEOUT_CYCLES, 16, maximum ACCESS-phase wait cycles (>=1).
REQ-002 Clocking SHALL be one clock and an asynchronous active-high reset: PCLK  in  1  clock; PRESET  in  1  async reset, active-high.
REQ-003 Command ports SHALL be: cmd_valid  in  1; cmd_ready  out  1; cmd_write  in  1; cmd_addr  in  ADDR_WIDTH; cmd_wdata  in  DATA_WIDTH; cmd_wstrb  in  DATA_WIDTH/8; cmd_prot  in  3.
REQ-004 Response ports SHALL be: rsp_valid  out  1; rsp_ready  in  1; rsp_rdata  out  DATA_WIDTH; rsp_err  out  1.
REQ-005 APB4 master ports SHALL be: PSEL, PENABLE, PWRITE  out  1 each; PPROT  out  3; PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  DATA_WIDTH/8; PRDATA  in  DATA_WIDTH; PREADY  in  1; PSLVERR  in  1.

Function
REQ-006 FSM states SHALL be IDLE, SETUP, ACCESS, RESP; one transaction in flight at most.
REQ-007 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cycle with cmd_valid && cmd_ready; IDLE->SETUP on acceptance.
REQ-008 On acceptance, write, addr, wdata, prot SHALL be registered; PSTRB SHALL register cmd_wstrb for writes, all-zero for reads.
REQ-009 SETUP SHALL drive PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS.
REQ-010 ACCESS SHALL drive PSEL=1, PENABLE=1; PADDR, PWRITE, PPROT, PWDATA, PSTRB SHALL stay stable from SETUP until the ACCESS cycle with PREADY=1.
REQ-011 In ACCESS with PREADY=1: rsp_rdata <= PRDATA for reads, 0 for writes; rsp_err <= PSLVERR; next state RESP; PSEL, PENABLE drop to 0 next cycle.
REQ-012 RESP SHALL hold rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready=1, then go to IDLE; rsp_valid SHALL be 0 in all other states.
REQ-013 Minimum command-accept to rsp_valid latency SHALL be 3 cycles (PREADY=1 in first ACCESS cycle); minimum issue interval SHALL be 4 cycles.
REQ-014 PSLVERR and PRDATA SHALL be ignored outside ACCESS cycles with PREADY=1.
REQ-015 cmd_valid held during non-IDLE states SHALL not be accepted nor alter registered fields.

Reset
REQ-016 PRESET assertion SHALL immediately force IDLE and drive PSEL, PENABLE, PWRITE, PPROT, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err to 0; cmd_ready SHALL be 0 while PRESET=1.
REQ-017 Reset mid-transaction SHALL abandon it without producing a response; first acceptance possible on the first PCLK edge after PRESET deasserts.

Configuration
REQ-018 Macro APB4_CMD_BRIDGE_TIMEOUT_EN SHALL enable an ACCESS wait counter; without it ACCESS waits for PREADY indefinitely and no counter logic exists.
REQ-019 With the macro, counter SHALL clear on SETUP and count each ACCESS cycle with PREADY=0; on the TIMEOUT_CYCLES-th such cycle the bridge SHALL go to RESP with rsp_err=1, rsp_rdata=0, dropping PSEL/PENABLE next cycle.
REQ-020 With the macro, PREADY=1 on the same cycle the count reaches TIMEOUT_CYCLES SHALL win: normal completion, no timeout.

Verification
REQ-021 Read addr 0x10, PRDATA=0xCAFEF00D, PREADY=1 first ACCESS cycle -> PSEL 2 cycles, PENABLE 1 cycle, PSTRB=0, rsp_rdata=0xCAFEF00D, rsp_err=0, rsp_valid 3 cycles after accept.
REQ-022 Write addr 0x24, wdata 0x12345678, wstrb 0x5, PREADY low 3 ACCESS cycles -> PADDR/PWDATA/PSTRB=0x5 stable 5 cycles, rsp_rdata=0, rsp_err=0.
REQ-023 Read with PSLVERR=1 at PREADY; rsp_ready held 0 for 4 cycles -> rsp_valid, rsp_err=1 stable 4 cycles, cmd_ready=0 throughout, IDLE after handshake.
REQ-024 TIMEOUT_EN defined, TIMEOUT_CYCLES=4, PREADY never asserted -> rsp_err=1, rsp_rdata=0 after 4 ACCESS cycles; variant with PREADY=1 on 4th cycle -> rsp_err=0.
REQ-025 PRESET pulsed during ACCESS -> all outputs 0 within same cycle, no rsp_valid; next command completes normally.

Source files
------------

// File: rtl/apb4_cmd_bridge.sv
// -----------------------------------------------------------------------------
// apb4_cmd_bridge
//
// Converts a simple valid/ready command stream into single APB4 transfers and
// returns each result on a valid/ready response channel. At most one transfer
// is in flight: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//
// Optional feature (compile-time macro):
//   APB4_CMD_BRIDGE_TIMEOUT_EN  - bound the ACCESS phase to TIMEOUT_CYCLES wait
//                                 cycles; on expiry the response carries
//                                 rsp_err=1, rsp_rdata=0. Without the macro the
//                                 ACCESS phase waits for PREADY indefinitely.
//
// Parameters:
//   DATA_WIDTH     - bus data width, multiple of 8
//   ADDR_WIDTH     - address width
//   TIMEOUT_CYCLES - maximum ACCESS wait cycles (>= 1), timeout build only
//
// Ports:
//   PCLK, PRESET          - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   - command handshake (ready only in IDLE)
//   cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot - command fields
//   rsp_valid/rsp_ready   - response handshake (valid only in RESP)
//   rsp_rdata, rsp_err    - response payload
//   PSEL, PENABLE, PWRITE, PPROT, PADDR, PWDATA, PSTRB - APB4 master outputs
//   PRDATA, PREADY, PSLVERR                            - APB4 slave inputs
// -----------------------------------------------------------------------------
module apb4_cmd_bridge #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,

  // Command channel
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  input  logic [2:0]              cmd_prot,

  // Response channel
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,

  // APB4 master
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [2:0]              PPROT,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Registered transfer fields, held stable from SETUP through ACCESS.
  logic                  pwrite_q, pwrite_d;
  logic [2:0]            pprot_q,  pprot_d;
  logic [ADDR_WIDTH-1:0] paddr_q,  paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [StrbWidth-1:0]  pstrb_q,  pstrb_d;

  // Registered response payload.
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q,   err_d;

  logic accept;
  logic complete;   // ACCESS cycle with PREADY=1
  logic timeout;    // ACCESS cycle that exhausts the wait budget

  // cmd_ready is gated by PRESET so no command can be seen as accepted while
  // the bridge is held in reset.
  assign cmd_ready = (state_q == StIdle) && !PRESET;
  assign accept    = cmd_valid && cmd_ready;
  assign complete  = (state_q == StAccess) && PREADY;

  // ---------------------------------------------------------------------------
  // Optional ACCESS wait counter
  // ---------------------------------------------------------------------------
`ifdef APB4_CMD_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntWidth = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CntWidth-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == StSetup) begin
      wait_cnt_d = '0;
    end else if ((state_q == StAccess) && !PREADY) begin
      wait_cnt_d = wait_cnt_q + CntWidth'(1);
    end
  end

  // The count holds the wait cycles already seen, so this cycle is the
  // TIMEOUT_CYCLES-th one when it equals TIMEOUT_CYCLES-1. PREADY=1 wins.
  assign timeout = (state_q == StAccess) && !PREADY &&
                   (wait_cnt_q == CntWidth'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSetup;
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (complete || timeout) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transfer field capture: only on acceptance, so a command held on cmd_valid
  // while busy cannot disturb the transfer in flight.
  // ---------------------------------------------------------------------------
  always_comb begin
    pwrite_d = pwrite_q;
    pprot_d  = pprot_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    if (accept) begin
      pwrite_d = cmd_write;
      pprot_d  = cmd_prot;
      paddr_d  = cmd_addr;
      pwdata_d = cmd_wdata;
      pstrb_d  = cmd_write ? cmd_wstrb : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Response capture: PRDATA/PSLVERR are only looked at on the completing
  // ACCESS cycle; writes always return zero data.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (complete) begin
      rdata_d = pwrite_q ? '0 : PRDATA;
      err_d   = PSLVERR;
    end else if (timeout) begin
      rdata_d = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= StIdle;
      pwrite_q <= 1'b0;
      pprot_q  <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      pprot_q  <= pprot_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign PSEL      = (state_q == StSetup) || (state_q == StAccess);
  assign PENABLE   = (state_q == StAccess);
  assign PWRITE    = pwrite_q;
  assign PPROT     = pprot_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;

  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb4_cmd_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb4_cmd_bridge
//
// Directed plus randomized commands. The driver pushes each accepted command
// to an APB slave model queue and its expected response (with the cycle it is
// due) to a scoreboard queue; the slave model checks bus fields, the response
// monitor pops and compares whenever rsp_valid is presented.
// -----------------------------------------------------------------------------
module tb_apb4_cmd_bridge;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 4;
`ifdef APB4_CMD_BRIDGE_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL, PENABLE, PWRITE;
  logic [2:0]    PPROT;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [3:0]    PSTRB;
  logic [DW-1:0] PRDATA  = '0;
  logic          PREADY  = 1'b0;
  logic          PSLVERR = 1'b0;

  apb4_cmd_bridge #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .cmd_prot (cmd_prot),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PPROT    (PPROT),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    strb;
    logic [2:0]    prot;
    int            waits;   // PREADY=0 ACCESS cycles before PREADY=1
    logic [DW-1:0] rdata;
    logic          err;
  } txn_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            due;     // cycle number at which rsp_valid must first show
  } exp_t;

  txn_t slv_q[$];
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_apb_ctrl"}, 64'({PSEL, PENABLE, PWRITE, PPROT, PSTRB}), 64'd0);
    chk({tag, "_apb_bus"},  64'({PADDR, PWDATA}), 64'd0);
    chk({tag, "_rsp"},      64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
  endtask

  function automatic txn_t mk(input logic wr, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [3:0] strb,
                              input logic [2:0] prot, input int waits,
                              input logic [DW-1:0] rdata, input logic err);
    txn_t t;
    t.wr = wr; t.addr = addr; t.wdata = wdata; t.strb = strb; t.prot = prot;
    t.waits = waits; t.rdata = rdata; t.err = err;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    return mk(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
              4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
              int'($urandom_range(0, 6)), $urandom, 1'($urandom_range(0, 1)));
  endfunction

  // Reference: the response depends only on the command and the slave's
  // behaviour; the wait budget runs out when waits reach TO.
  function automatic exp_t model(input txn_t t, input int acc_cyc);
    exp_t e;
    if (TimeoutEn && t.waits >= int'(TO)) begin
      e.rdata = '0;
      e.err   = 1'b1;
      e.due   = acc_cyc + 2 + int'(TO);
    end else begin
      e.rdata = t.wr ? '0 : t.rdata;
      e.err   = t.err;
      e.due   = acc_cyc + 3 + t.waits;
    end
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic issue(input txn_t t, input bit abandon);
    int n;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = t.wr;
    cmd_addr  = t.addr;
    cmd_wdata = t.wdata;
    cmd_wstrb = t.strb;
    cmd_prot  = t.prot;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    chk("cmd_accept", 64'(cmd_ready), 64'd1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    slv_q.push_back(t);
    if (!abandon) exp_q.push_back(model(t, cyc));
    @(negedge PCLK);
    // Keep cmd_valid high with unrelated fields while the bridge is busy.
    if (!abandon && $urandom_range(0, 1) == 1) begin
      cmd_write = ~cmd_write;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_wstrb = 4'($urandom_range(0, 15));
      cmd_prot  = 3'($urandom_range(0, 7));
      @(negedge PCLK);
    end
    cmd_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // APB slave model
  // ---------------------------------------------------------------------------
  txn_t cur;
  int   acc_n = 0;
  bit   have  = 1'b0;

  task automatic chk_fields();
    chk("apb_ctrl", 64'({PWRITE, PPROT, PSTRB}),
        64'({cur.wr, cur.prot, (cur.wr ? cur.strb : 4'h0)}));
    chk("paddr",  64'(PADDR),  64'(cur.addr));
    chk("pwdata", 64'(PWDATA), 64'(cur.wdata));
  endtask

  always @(negedge PCLK) begin
    if (PSEL && !PENABLE) begin
      if (slv_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_setup: got PSEL=1 with no command issued, required PSEL=0");
        have = 1'b0;
      end else begin
        cur   = slv_q.pop_front();
        have  = 1'b1;
        acc_n = 0;
        chk_fields();
      end
      PREADY  = 1'($urandom_range(0, 1));
      PRDATA  = $urandom;
      PSLVERR = 1'($urandom_range(0, 1));
    end else if (PSEL && PENABLE && have) begin
      chk_fields();
      if (acc_n == cur.waits) begin
        PREADY  = 1'b1;
        PRDATA  = cur.rdata;
        PSLVERR = cur.err;
      end else begin
        PREADY  = 1'b0;
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom_range(0, 1));
      end
      acc_n++;
    end else begin
      // Junk outside ACCESS must be ignored by the bridge.
      PREADY  = 1'($urandom_range(0, 1));
      PRDATA  = $urandom;
      PSLVERR = 1'($urandom_range(0, 1));
    end
  end

  // ---------------------------------------------------------------------------
  // Response monitor / scoreboard
  // ---------------------------------------------------------------------------
  bit prev_v = 1'b0;
  int hold   = 0;

  always @(negedge PCLK) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 with nothing outstanding, required 0");
        rsp_ready = 1'b1;
      end else begin
        if (!prev_v) begin
          chk("rsp_latency", 64'(cyc), 64'(exp_q[0].due));
          hold = int'($urandom_range(0, 4));
        end
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_q[0].rdata));
        chk("rsp_err", 64'(rsp_err), 64'(exp_q[0].err));
        chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
        if (hold == 0) begin
          rsp_ready = 1'b1;
          void'(exp_q.pop_front());
        end else begin
          rsp_ready = 1'b0;
          hold--;
        end
      end
    end else begin
      rsp_ready = 1'($urandom_range(0, 1));
    end
    prev_v = rsp_valid;
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    txn_t dir[5];
    PRESET    = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    cmd_prot  = '0;
    #2 PRESET = 1'b1;
    #1 chk_outputs_zero("reset");
    @(negedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    #1 chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

    dir[0] = mk(1'b0, 32'h10, 32'h0, 4'hF, 3'h0, 0, 32'hCAFE_F00D, 1'b0);
    dir[1] = mk(1'b1, 32'h24, 32'h1234_5678, 4'h5, 3'h2, 3, 32'hAAAA_5555, 1'b0);
    dir[2] = mk(1'b0, 32'h30, 32'h0, 4'h0, 3'h1, 1, 32'hDEAD_BEEF, 1'b1);
    dir[3] = mk(1'b0, 32'h40, 32'h0, 4'h3, 3'h0, int'(TO) - 1, 32'h0BAD_CAFE, 1'b0);
    dir[4] = mk(1'b0, 32'h44, 32'h0, 4'h0, 3'h7, 6, 32'h1111_2222, 1'b0);
    foreach (dir[i]) issue(dir[i], 1'b0);

    // Reset during ACCESS: outputs clear at once and no response follows.
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    issue(mk(1'b1, 32'h5C, 32'hF0F0_1234, 4'hC, 3'h5, 5, 32'h0, 1'b0), 1'b1);
    @(negedge PCLK);
    chk("abandon_in_access", 64'({PSEL, PENABLE}), 64'h3);
    #2 PRESET = 1'b1;
    #1 chk_outputs_zero("mid_reset");
    @(negedge PCLK);
    PRESET = 1'b0;
    #1 chk("cmd_ready_after_mid_reset", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 40; i++) issue(rand_txn(), 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge PCLK);
      n++;
    end
    chk("drain_rsp", 64'(exp_q.size()), 64'd0);
    chk("drain_apb", 64'(slv_q.size()), 64'd0);
    repeat (3) @(negedge PCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
